// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//   Moore serial-pattern detector for a runtime-programmable PAT_W-bit pattern.
//   The state is the length of the longest pattern prefix that is also a suffix
//   of the bits consumed so far (0..PAT_W), binary encoded. The KMP-style
//   fallback on a mismatch is derived combinationally from the pattern
//   register, so a newly loaded pattern takes effect on the next consumed bit
//   with no table to rebuild.
//
//   Optional feature macro: SEQ_DET_COUNT_EN
//     defined   -> saturating match counter on match_count, cleared by cnt_clr
//     undefined -> match_count tied to zero, cnt_clr ignored, no counter flops
// -----------------------------------------------------------------------------
module seq_detector #(
    parameter int                 PAT_W       = 4,
    parameter logic [PAT_W-1:0]   DEFAULT_PAT = 4'b1011,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               a,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_W-1:0]   pattern_in,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count
);

    // State width covers 0..PAT_W; history vector is one bit wider than the
    // pattern so that "prefix(k) followed by the new bit" always fits.
    localparam int             SW     = $clog2(PAT_W + 1);
    localparam int             LW     = PAT_W + 1;
    localparam logic [SW-1:0]  FULL_S = SW'(PAT_W);

    // -------------------------------------------------------------------------
    // Next-state function.
    //   k   : current matched prefix length (0..PAT_W)
    //   b   : incoming bit
    //   The string seen is prefix(k) followed by b. The new state is the largest
    //   m (1..PAT_W, m <= k+1) for which the last m bits of that string equal
    //   prefix(m). Because m never exceeds PAT_W, calling this with k = PAT_W
    //   behaves exactly like stepping from the longest proper border, which is
    //   the overlapping-match behaviour.
    //   The pattern's MSB is the first received bit, so prefix(m) as a value is
    //   simply pat >> (PAT_W - m).
    // -------------------------------------------------------------------------
    function automatic logic [SW-1:0] kmp_next(
        input logic [PAT_W-1:0] pat,
        input logic [SW-1:0]    k,
        input logic             b
    );
        logic [LW-1:0] hist;
        logic [LW-1:0] msk;
        logic [LW-1:0] pfx;
        logic [SW-1:0] best;
        hist = (({1'b0, pat} >> (FULL_S - k)) << 1) | {{PAT_W{1'b0}}, b};
        best = {SW{1'b0}};
        for (int m = 1; m <= PAT_W; m++) begin
            msk = {LW{1'b1}} >> (LW - m);
            pfx = {1'b0, pat} >> (PAT_W - m);
            if ((SW'(m - 1) <= k) && ((hist & msk) == pfx)) begin
                best = SW'(m);
            end else begin
                best = best;
            end
        end
        return best;
    endfunction

    logic [SW-1:0]    state_r;
    logic [SW-1:0]    state_nxt_s;
    logic [SW-1:0]    k_eff_s;
    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] pat_nxt_s;
    logic             consume_s;
    logic             y_r;

    // Effective starting point for the step: a completed match in
    // non-overlapping mode restarts from empty; an out-of-range state code
    // (unreachable in normal operation) also falls back to empty.
    always_comb begin
        k_eff_s = state_r;
        if (state_r > FULL_S) begin
            k_eff_s = {SW{1'b0}};
        end else if ((state_r == FULL_S) && !overlap) begin
            k_eff_s = {SW{1'b0}};
        end else begin
            k_eff_s = state_r;
        end
    end

    // Next-state and pattern update: pattern load beats a sample strobe,
    // and with neither active everything holds.
    always_comb begin
        state_nxt_s = state_r;
        pat_nxt_s   = pat_r;
        consume_s   = 1'b0;
        if (pat_load) begin
            pat_nxt_s   = pattern_in;
            state_nxt_s = {SW{1'b0}};
        end else if (en) begin
            consume_s   = 1'b1;
            state_nxt_s = kmp_next(pat_r, k_eff_s, a);
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, pattern and match-flag registers; y is a registered decode of
    // the next state so it carries no combinational path from a.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= {SW{1'b0}};
            pat_r   <= DEFAULT_PAT;
            y_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pat_r   <= pat_nxt_s;
            y_r     <= (state_nxt_s == FULL_S);
        end
    end

    assign y = y_r;

`ifdef SEQ_DET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Saturating match counter: clear beats increment; a pattern load
    // leaves the count untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (consume_s && (state_nxt_s == FULL_S) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign match_count = cnt_r;
`else
    logic unused_s;

    assign match_count = {CNT_W{1'b0}};
    assign unused_s    = ^{cnt_clr, consume_s};
`endif

endmodule
